mem_arbiter: RTL and testbench

Single-port RAM arbiter directly downstream of the data cache and the instruction cache. It grants the RAM to one requester at a time and holds the grant for multi-word block transfers (dirty write-back, two-word fills) so they are not interleaved. It steers address, data and enables to the RAM and returns load data and wait signals to each cache. The data cache has priority, with a bounded-starvation rule for the instruction cache.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/arb_fairness.sv | 30 +++
 rtl/mem_arbiter.sv | 69 ++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM-status and arbiter-state types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;
endpackage

// File: rtl/arb_fairness.sv
// arb_fairness: remembers who was granted last and how often the icache lost, forcing icache once starved
module arb_fairness
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  arb_state_t state,
  input  logic       dreq,
  input  logic       iREN,
  output logic       forceI
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic          lastD;
  logic [SW-1:0] streak;
  assign forceI = lastD && streak >= SW'(STARVE_LIMIT);
  // update history when a grant is released
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) begin
      lastD  <= 1'b0;
      streak <= '0;
    end else if (state == DGRANT && !dreq) begin
      lastD  <= 1'b1;
      streak <= !iREN ? '0 : streak == SW'(STARVE_LIMIT) ? streak : streak + 1'b1;
    end else if (state == IGRANT && !iREN) begin
      lastD  <= 1'b0;
      streak <= '0;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between dcache (priority) and icache with burst lock
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ERRCNT_W     = 8
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                iREN,
  input  word_t               iaddr,
  output word_t               iload,
  output logic                iwait,
  input  logic                dREN,
  input  logic                dWEN,
  input  word_t               daddr,
  input  word_t               dstore,
  output word_t               dload,
  output logic                dwait,
  output logic                ramREN,
  output logic                ramWEN,
  output word_t               ramaddr,
  output word_t               ramstore,
  input  word_t               ramload,
  input  logic [1:0]          ramstate,
  output logic [ERRCNT_W-1:0] err_count
);
  arb_state_t state;
  logic       dreq, forceI, dGrant, iGrant, access, ramErr;
  assign dreq   = dREN | dWEN;
  assign dGrant = state == DGRANT;
  assign iGrant = state == IGRANT;
  assign access = ramstate_t'(ramstate) == ACCESS;
  assign ramErr = ramstate_t'(ramstate) == ERROR;

  arb_fairness #(.STARVE_LIMIT(STARVE_LIMIT)) uFair (
    .CLK   (CLK),
    .nRST  (nRST),
    .state (state),
    .dreq  (dreq),
    .iREN  (iREN),
    .forceI(forceI)
  );

  // grant FSM: dcache wins ties unless icache is starved; grants held while requested
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) state <= IDLE;
    else
      case (state)
        IDLE:    state <= dreq && !(iREN && forceI) ? DGRANT : iREN ? IGRANT : IDLE;
        DGRANT:  if (!dreq) state <= IDLE;
        IGRANT:  if (!iREN) state <= IDLE;
        default: state <= IDLE;
      endcase

  // saturating count of RAM error cycles seen while someone holds the grant
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) err_count <= '0;
    else if (state != IDLE && ramErr && err_count != '1) err_count <= err_count + 1'b1;

  assign ramWEN   = dGrant && dWEN;
  assign ramREN   = iGrant || (dGrant && dREN && !dWEN);
  assign ramaddr  = dGrant ? daddr : iGrant ? iaddr : '0;
  assign ramstore = dGrant ? dstore : '0;
  assign iwait    = !(iGrant && access);
  assign dwait    = !(dGrant && access);
  assign iload    = iGrant ? ramload : '0;
  assign dload    = dGrant ? ramload : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, corner sequences and randomized model comparison for mem_arbiter
module tb_mem_arbiter;
  logic        CLK, nRST, iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN;
  logic [31:0] iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic [7:0]  err_count;
  int          checks = 0, failures = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .ERRCNT_W(8)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err_count(err_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        iREN, dREN, dWEN;
    logic [31:0] daddr, dstore;
    logic [1:0]  rs;
    logic        eIwait, eDwait, eRen, eWen;
    logic [31:0] eAddr, eStore;
  } vec_t;
  vec_t tbl[14];

  // reference model: grant owner 0 none, 1 icache, 2 dcache
  int mOwner, mStreak, mErr;
  bit mLastD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = 2'd0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic modelReset();
    mOwner = 0; mStreak = 0; mErr = 0; mLastD = 0;
  endtask

  task automatic modelCheck();
    bit    dq;
    logic [31:0] eAddr;
    dq    = dREN || dWEN;
    eAddr = mOwner == 2 ? daddr : mOwner == 1 ? iaddr : 32'd0;
    chk("rnd_ramWEN", ramWEN, mOwner == 2 && dWEN);
    chk("rnd_ramREN", ramREN, mOwner == 1 || (mOwner == 2 && dREN && !dWEN));
    chk("rnd_ramaddr", ramaddr, eAddr);
    chk("rnd_ramstore", ramstore, mOwner == 2 ? dstore : 32'd0);
    chk("rnd_iwait", iwait, !(mOwner == 1 && ramstate == 2'd2));
    chk("rnd_dwait", dwait, !(mOwner == 2 && ramstate == 2'd2));
    chk("rnd_iload", iload, mOwner == 1 ? ramload : 32'd0);
    chk("rnd_dload", dload, mOwner == 2 ? ramload : 32'd0);
    chk("rnd_err", {24'd0, err_count}, mErr);
    if (!dq && mOwner == 0 && !iREN) chk("rnd_idle_quiet", {ramREN, ramWEN}, 0);
  endtask

  task automatic modelStep();
    bit dq;
    dq = dREN || dWEN;
    if (mOwner != 0 && ramstate == 2'd3 && mErr < 255) mErr++;
    if (mOwner == 0) mOwner = dq ? ((iREN && mLastD && mStreak >= 4) ? 1 : 2) : (iREN ? 1 : 0);
    else if (mOwner == 2 && !dq) begin
      mOwner = 0; mLastD = 1;
      mStreak = iREN ? (mStreak < 4 ? mStreak + 1 : 4) : 0;
    end else if (mOwner == 1 && !iREN) begin
      mOwner = 0; mLastD = 0; mStreak = 0;
    end
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 32'h0,   32'h0,    2'd0, 1, 1, 0, 0, 32'h0,   32'h0};
    tbl[1]  = '{1, 0, 0, 32'h0,   32'h0,    2'd2, 0, 1, 1, 0, 32'h40,  32'h0};
    tbl[2]  = '{0, 1, 0, 32'h0,   32'h0,    2'd1, 1, 1, 1, 0, 32'h40,  32'h0};
    tbl[3]  = '{1, 1, 0, 32'h200, 32'h0,    2'd0, 1, 1, 0, 0, 32'h0,   32'h0};
    tbl[4]  = '{1, 1, 0, 32'h200, 32'h0,    2'd2, 1, 0, 1, 0, 32'h200, 32'h0};
    tbl[5]  = '{1, 0, 0, 32'h200, 32'h0,    2'd0, 1, 1, 0, 0, 32'h200, 32'h0};
    tbl[6]  = '{1, 0, 0, 32'h0,   32'h0,    2'd0, 1, 1, 0, 0, 32'h0,   32'h0};
    tbl[7]  = '{0, 0, 1, 32'h100, 32'hAAAA, 2'd2, 0, 1, 1, 0, 32'h40,  32'h0};
    tbl[8]  = '{0, 0, 1, 32'h100, 32'hAAAA, 2'd0, 1, 1, 0, 0, 32'h0,   32'h0};
    tbl[9]  = '{0, 0, 1, 32'h100, 32'hAAAA, 2'd2, 1, 0, 0, 1, 32'h100, 32'hAAAA};
    tbl[10] = '{0, 0, 1, 32'h104, 32'hBBBB, 2'd2, 1, 0, 0, 1, 32'h104, 32'hBBBB};
    tbl[11] = '{0, 1, 1, 32'h108, 32'hCCCC, 2'd1, 1, 1, 0, 1, 32'h108, 32'hCCCC};
    tbl[12] = '{0, 0, 0, 32'h108, 32'h0,    2'd0, 1, 1, 0, 0, 32'h108, 32'h0};
    tbl[13] = '{0, 0, 0, 32'h0,   32'h0,    2'd0, 1, 1, 0, 0, 32'h0,   32'h0};

    doReset();
    #4;
    chk("reset_iwait", iwait, 1);
    chk("reset_dwait", dwait, 1);
    chk("reset_ram_en", {ramREN, ramWEN}, 0);
    chk("reset_ramaddr", ramaddr, 0);
    chk("reset_err", {24'd0, err_count}, 0);
    adv();

    // table vectors
    doReset();
    iaddr = 32'h40;
    for (int i = 0; i < 14; i++) begin
      iREN = tbl[i].iREN; dREN = tbl[i].dREN; dWEN = tbl[i].dWEN;
      daddr = tbl[i].daddr; dstore = tbl[i].dstore; ramstate = tbl[i].rs;
      ramload = 32'hCAFE0000 + i;
      #4;
      chk($sformatf("tbl%0d_iwait", i), iwait, tbl[i].eIwait);
      chk($sformatf("tbl%0d_dwait", i), dwait, tbl[i].eDwait);
      chk($sformatf("tbl%0d_ramREN", i), ramREN, tbl[i].eRen);
      chk($sformatf("tbl%0d_ramWEN", i), ramWEN, tbl[i].eWen);
      chk($sformatf("tbl%0d_ramaddr", i), ramaddr, tbl[i].eAddr);
      chk($sformatf("tbl%0d_ramstore", i), ramstore, tbl[i].eStore);
      if (!tbl[i].eIwait) chk($sformatf("tbl%0d_iload", i), iload, 32'hCAFE0000 + i);
      if (!tbl[i].eDwait) chk($sformatf("tbl%0d_dload", i), dload, 32'hCAFE0000 + i);
      adv();
    end

    // starvation: icache forced after four consecutive dcache bursts
    doReset();
    iREN = 1; iaddr = 32'h40; daddr = 32'h500; ramstate = 2'd2;
    for (int k = 0; k < 4; k++) begin
      dREN = 1;
      #4 chk("starve_idle_bubble", {ramREN, ramWEN}, 0);
      adv();
      #4 chk("starve_dgrant_addr", ramaddr, 32'h500);
      chk("starve_iwait", iwait, 1);
      adv();
      dREN = 0;
      adv();
    end
    dREN = 1;
    adv();
    #4;
    chk("starve_igrant_addr", ramaddr, 32'h40);
    chk("starve_igrant_iwait", iwait, 0);
    chk("starve_igrant_dwait", dwait, 1);
    adv();

    // RAM errors during a dcache read
    doReset();
    dREN = 1; daddr = 32'h300;
    adv();
    ramstate = 2'd3;
    for (int k = 0; k < 3; k++) begin
      #4 chk("err_dwait", dwait, 1);
      chk("err_ramREN_retry", ramREN, 1);
      adv();
    end
    ramstate = 2'd2; ramload = 32'h12345678;
    #4;
    chk("err_access_dwait", dwait, 0);
    chk("err_access_dload", dload, 32'h12345678);
    chk("err_count3", {24'd0, err_count}, 3);
    adv();

    // async reset in the middle of a dcache write
    doReset();
    dWEN = 1; daddr = 32'h600; dstore = 32'h77; ramstate = 2'd3;
    adv();
    #4 chk("rst_pre_ramWEN", ramWEN, 1);
    adv();
    ramstate = 2'd0;
    #4 chk("rst_pre_err", {24'd0, err_count}, 1);
    nRST = 0;
    #1;
    chk("rst_ramWEN_now", ramWEN, 0);
    chk("rst_err_now", {24'd0, err_count}, 0);
    chk("rst_state_idle", {30'd0, dut.state}, 0);
    adv();
    nRST = 1;
    #4 chk("rst_release_bubble", ramWEN, 0);
    adv();
    #4 chk("rst_regrant", ramWEN, 1);
    adv();

    // randomized comparison against the reference model
    doReset();
    modelReset();
    for (int i = 0; i < 3000; i++) begin
      nRST     = $urandom_range(0, 199) != 0;
      iREN     = $urandom_range(0, 9) < 6;
      dREN     = $urandom_range(0, 9) < 4;
      dWEN     = $urandom_range(0, 9) < 3;
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      if (!nRST) modelReset();
      #4 modelCheck();
      @(posedge CLK);
      if (nRST) modelStep();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
